// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative RV32M divider: op codes, FSM states,
// width constants and the conditional two's-complement helper.
package div_unit_pkg;

   localparam int DIV_DATA_W = 32;
   localparam int DIV_CNT_W  = 5;

   // RV32M divide/remainder operation codes as issued by the ALU
   typedef enum logic [1:0] {
      DIV_OP_DIV  = 2'b00,
      DIV_OP_DIVU = 2'b01,
      DIV_OP_REM  = 2'b10,
      DIV_OP_REMU = 2'b11
   } div_op_e;

   // Divider FSM states
   typedef enum logic [1:0] {
      DIV_ST_IDLE = 2'b00,
      DIV_ST_CALC = 2'b01,
      DIV_ST_FIX  = 2'b10
   } div_state_e;

   localparam logic [DIV_DATA_W-1:0] DIV_ZERO     = {DIV_DATA_W{1'b0}};
   localparam logic [DIV_DATA_W-1:0] DIV_ONE      = {{(DIV_DATA_W-1){1'b0}}, 1'b1};
   localparam logic [DIV_DATA_W-1:0] DIV_ALL_ONES = {DIV_DATA_W{1'b1}};
   localparam logic [DIV_DATA_W-1:0] DIV_INT_MIN  = {1'b1, {(DIV_DATA_W-1){1'b0}}};

   localparam logic [DIV_CNT_W-1:0]  DIV_CNT_ZERO = {DIV_CNT_W{1'b0}};
   localparam logic [DIV_CNT_W-1:0]  DIV_CNT_ONE  = {{(DIV_CNT_W-1){1'b0}}, 1'b1};
   localparam logic [DIV_CNT_W-1:0]  DIV_CNT_LAST = {DIV_CNT_W{1'b1}};

   // Two's-complement negate when neg is set, pass-through otherwise
   function automatic logic [DIV_DATA_W-1:0] cond_neg(input logic [DIV_DATA_W-1:0] v,
                                                      input logic                  neg);
      logic [DIV_DATA_W-1:0] r;
      if (neg) begin
         r = ~v + DIV_ONE;
      end else begin
         r = v;
      end
      return r;
   endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the
// divisor and keep the difference only when it does not go negative.
module div_unit_step
   import div_unit_pkg::*;
#(
   parameter int DATA_W = DIV_DATA_W
) (
   input  logic [DATA_W-1:0] rem_i,
   input  logic [DATA_W-1:0] quo_i,
   input  logic [DATA_W-1:0] dvs_i,
   output logic [DATA_W-1:0] rem_o,
   output logic [DATA_W-1:0] quo_o
);

   logic [DATA_W:0] rem_sh_s;
   logic [DATA_W:0] trial_s;
   logic            ge_s;

   assign rem_sh_s = {rem_i, quo_i[DATA_W-1]};
   assign trial_s  = rem_sh_s - {1'b0, dvs_i};
   // A shifted remainder above 2^DATA_W always covers the divisor; otherwise
   // the top bit of the 33-bit trial is the borrow.
   assign ge_s     = rem_sh_s[DATA_W] | ~trial_s[DATA_W];

   // Restore-or-keep selection and new quotient bit
   always_comb begin
      rem_o = rem_sh_s[DATA_W-1:0];
      quo_o = {quo_i[DATA_W-2:0], 1'b0};
      if (ge_s) begin
         rem_o = trial_s[DATA_W-1:0];
         quo_o = {quo_i[DATA_W-2:0], 1'b1};
      end else begin
         rem_o = rem_sh_s[DATA_W-1:0];
      end
   end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU. Divide by zero
// and signed overflow are answered directly from IDLE; everything else takes
// 32 CALC steps plus a FIX cycle that applies signs and registers the result.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int DATA_W = DIV_DATA_W,
   parameter int CNT_W  = DIV_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] in_0,
   input  logic [DATA_W-1:0] in_1,
   input  logic              flush,
   output logic              busy,
   output logic              valid,
   output logic [DATA_W-1:0] out,
   output logic              dz
);

   div_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] rem_q, rem_d;
   logic [DATA_W-1:0] quo_q, quo_d;
   logic [DATA_W-1:0] dvs_q, dvs_d;
   logic              qneg_q, qneg_d;
   logic              rneg_q, rneg_d;
   logic              rsel_q, rsel_d;
   logic              busy_q, busy_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] out_q, out_d;
   logic              dz_q, dz_d;

   logic [DATA_W-1:0] step_rem_s;
   logic [DATA_W-1:0] step_quo_s;
   logic              signed_s;

   // DIV and REM (op[0]==0) are the signed flavours; op[1] selects remainder
   assign signed_s = ~op[0];

   div_unit_step #(.DATA_W(DATA_W)) u_step (
      .rem_i (rem_q),
      .quo_i (quo_q),
      .dvs_i (dvs_q),
      .rem_o (step_rem_s),
      .quo_o (step_quo_s)
   );

   // State and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= DIV_ST_IDLE;
         cnt_q   <= DIV_CNT_ZERO;
         rem_q   <= DIV_ZERO;
         quo_q   <= DIV_ZERO;
         dvs_q   <= DIV_ZERO;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         rsel_q  <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         out_q   <= DIV_ZERO;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         rsel_q  <= rsel_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         out_q   <= out_d;
         dz_q    <= dz_d;
      end
   end

   // Next-state and output decode; flush overrides everything
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      rsel_d  = rsel_q;
      busy_d  = busy_q;
      valid_d = 1'b0;
      out_d   = out_q;
      dz_d    = dz_q;
      if (flush) begin
         state_d = DIV_ST_IDLE;
         cnt_d   = DIV_CNT_ZERO;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            DIV_ST_IDLE: begin
               busy_d = 1'b0;
               if (start) begin
                  dz_d   = 1'b0;
                  rsel_d = op[1];
                  if (in_1 == DIV_ZERO) begin
                     out_d   = op[1] ? in_0 : DIV_ALL_ONES;
                     dz_d    = 1'b1;
                     valid_d = 1'b1;
                  end else if (signed_s && (in_0 == DIV_INT_MIN) && (in_1 == DIV_ALL_ONES)) begin
                     out_d   = op[1] ? DIV_ZERO : DIV_INT_MIN;
                     valid_d = 1'b1;
                  end else begin
                     state_d = DIV_ST_CALC;
                     busy_d  = 1'b1;
                     cnt_d   = DIV_CNT_ZERO;
                     rem_d   = DIV_ZERO;
                     quo_d   = cond_neg(in_0, signed_s & in_0[DATA_W-1]);
                     dvs_d   = cond_neg(in_1, signed_s & in_1[DATA_W-1]);
                     qneg_d  = signed_s & (in_0[DATA_W-1] ^ in_1[DATA_W-1]);
                     rneg_d  = signed_s & in_0[DATA_W-1];
                  end
               end else begin
                  state_d = DIV_ST_IDLE;
               end
            end
            DIV_ST_CALC: begin
               rem_d = step_rem_s;
               quo_d = step_quo_s;
               cnt_d = cnt_q + DIV_CNT_ONE;
               if (cnt_q == DIV_CNT_LAST) begin
                  state_d = DIV_ST_FIX;
               end else begin
                  state_d = DIV_ST_CALC;
               end
            end
            DIV_ST_FIX: begin
               out_d   = rsel_q ? cond_neg(rem_q, rneg_q) : cond_neg(quo_q, qneg_q);
               valid_d = 1'b1;
               busy_d  = 1'b0;
               state_d = DIV_ST_IDLE;
            end
            default: begin
               state_d = DIV_ST_IDLE;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   assign busy  = busy_q;
   assign valid = valid_q;
   assign out   = out_q;
   assign dz    = dz_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table plus hand sequences for
// flush, reset, back-to-back issue and start-while-busy. Expected results are
// queued at issue time and compared when valid pulses.
module tb_div_unit;
   import div_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] in_0;
   logic [31:0] in_1;
   logic        flush;
   logic        busy;
   logic        valid;
   logic [31:0] out;
   logic        dz;

   always #5 clk = ~clk;

   div_unit dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .in_0  (in_0),
      .in_1  (in_1),
      .flush (flush),
      .busy  (busy),
      .valid (valid),
      .out   (out),
      .dz    (dz)
   );

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic        dz;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] q;
      logic        dz;
      int          due;
   } exp_t;

   localparam int LAT_N = 33;  // accept edge to valid-visible edge, iterative path
   localparam int LAT_S = 0;   // special cases: valid in the cycle after accept

   exp_t sb[$];
   int   pass_cnt   = 0;
   int   total_cnt  = 0;
   int   edge_cnt   = 0;
   int   valid_seen = 0;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Result monitor: pop the scoreboard on each valid pulse
   always @(negedge clk) begin
      exp_t e;
      if (valid === 1'b1) begin
         valid_seen++;
         if (sb.size() == 0) begin
            check("unexpected_valid", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("out", out, e.q);
            check("dz", {31'd0, dz}, {31'd0, e.dz});
            check("latency", 32'(edge_cnt), 32'(e.due));
            check("busy_at_valid", {31'd0, busy}, 32'd0);
         end
      end
   end

   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic d, input int lat, input bit push);
      exp_t e;
      @(posedge clk); #1;
      start = 1'b1; op = o; in_0 = a; in_1 = b;
      if (push) begin
         e.q = q; e.dz = d; e.due = edge_cnt + 1 + lat;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 80 && sb.size() != 0; i++) @(posedge clk);
      if (sb.size() != 0) begin
         check("result_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
   endtask

   vec_t vecs[18];

   initial begin
      logic [31:0] ra, rb;
      logic [1:0]  ro;
      int          seen_before;
      exp_t        e;

      vecs[0]  = '{DIV_OP_DIVU, 32'd100,        32'd7,          32'd14,         1'b0, LAT_N};
      vecs[1]  = '{DIV_OP_REMU, 32'd100,        32'd7,          32'd2,          1'b0, LAT_N};
      vecs[2]  = '{DIV_OP_DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  1'b0, LAT_N};
      vecs[3]  = '{DIV_OP_REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  1'b0, LAT_N};
      vecs[4]  = '{DIV_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, LAT_S};
      vecs[5]  = '{DIV_OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000,  1'b0, LAT_S};
      vecs[6]  = '{DIV_OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1, LAT_S};
      vecs[7]  = '{DIV_OP_REMU, 32'd5,          32'd0,          32'd5,          1'b1, LAT_S};
      vecs[8]  = '{DIV_OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0, LAT_N};
      vecs[9]  = '{DIV_OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0, LAT_N};
      vecs[10] = '{DIV_OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0, LAT_N};
      vecs[11] = '{DIV_OP_REMU, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          1'b0, LAT_N};
      vecs[12] = '{DIV_OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0, LAT_N};
      vecs[13] = '{DIV_OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1, LAT_S};
      vecs[14] = '{DIV_OP_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1'b1, LAT_S};
      vecs[15] = '{DIV_OP_DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  1'b0, LAT_N};
      vecs[16] = '{DIV_OP_REM,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'hFFFF_FFFF,  1'b0, LAT_N};
      vecs[17] = '{DIV_OP_DIVU, 32'd0,          32'd5,          32'd0,          1'b0, LAT_N};

      reset = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; in_0 = 32'd0; in_1 = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy",  {31'd0, busy},  32'd0);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_out",   out,            32'd0);
      check("rst_dz",    {31'd0, dz},    32'd0);
      reset = 1'b1;

      // Vector table
      for (int i = 0; i < 18; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].dz, vecs[i].lat, 1'b1);
         drain();
      end

      // Random unsigned operations against the language's own / and %
      for (int i = 0; i < 8; i++) begin
         ra = $urandom;
         rb = $urandom_range(1, 1000);
         ro = (i % 2 == 0) ? DIV_OP_DIVU : DIV_OP_REMU;
         issue(ro, ra, rb, (ro == DIV_OP_REMU) ? (ra % rb) : (ra / rb), 1'b0, LAT_N, 1'b1);
         drain();
      end

      // Back-to-back: second start lands in the valid cycle of a divide-by-zero
      @(posedge clk); #1;
      start = 1'b1; op = DIV_OP_DIVU; in_0 = 32'd5; in_1 = 32'd0;
      e.q = 32'hFFFF_FFFF; e.dz = 1'b1; e.due = edge_cnt + 1 + LAT_S; sb.push_back(e);
      @(posedge clk); #1;
      op = DIV_OP_DIVU; in_0 = 32'd9; in_1 = 32'd3;
      e.q = 32'd3; e.dz = 1'b0; e.due = edge_cnt + 1 + LAT_N; sb.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      drain();

      // Start pulses while busy are ignored
      issue(DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, LAT_N, 1'b1);
      for (int k = 0; k < 3; k++) begin
         repeat (4) @(posedge clk);
         #1;
         start = 1'b1; op = DIV_OP_REMU; in_0 = 32'd50; in_1 = 32'd5;
         @(posedge clk); #1;
         start = 1'b0;
      end
      drain();

      // Flush mid-CALC: no result, then a fresh operation completes normally
      seen_before = valid_seen;
      issue(DIV_OP_DIVU, 32'd1000, 32'd3, 32'd0, 1'b0, LAT_N, 1'b0);
      check("busy_in_calc", {31'd0, busy}, 32'd1);
      repeat (8) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_busy",  {31'd0, busy},  32'd0);
      check("flush_valid", {31'd0, valid}, 32'd0);
      repeat (40) @(posedge clk);
      check("flush_no_valid", 32'(valid_seen), 32'(seen_before));
      issue(DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, 1'b0, LAT_N, 1'b1);
      drain();

      // Asynchronous reset mid-CALC
      seen_before = valid_seen;
      issue(DIV_OP_DIVU, 32'd100, 32'd7, 32'd0, 1'b0, LAT_N, 1'b0);
      repeat (10) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("mid_rst_busy",  {31'd0, busy},  32'd0);
      check("mid_rst_valid", {31'd0, valid}, 32'd0);
      check("mid_rst_out",   out,            32'd0);
      check("mid_rst_dz",    {31'd0, dz},    32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (40) @(posedge clk);
      check("rst_no_valid", 32'(valid_seen), 32'(seen_before));
      issue(DIV_OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0, LAT_N, 1'b1);
      drain();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   // Global time bound
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
